// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Round-robin front end that shares one mem_system between the instruction
// fetch port (I) and the data port (D). The winning request is latched and
// replayed on the downstream Rd/Wr handshake until Done. The result goes back
// to the winner as a one-cycle done pulse. A hung transaction is aborted with
// done+err after TIMEOUT_CYCLES cycles in BUSY.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,

    // Instruction-fetch requester
    input  logic [15:0] i_addr,
    input  logic [15:0] i_data_in,
    input  logic        i_rd,
    input  logic        i_wr,
    output logic [15:0] i_data_out,
    output logic        i_done,
    output logic        i_stall,
    output logic        i_cache_hit,
    output logic        i_err,

    // Data requester
    input  logic [15:0] d_addr,
    input  logic [15:0] d_data_in,
    input  logic        d_rd,
    input  logic        d_wr,
    output logic [15:0] d_data_out,
    output logic        d_done,
    output logic        d_stall,
    output logic        d_cache_hit,
    output logic        d_err,

    // Shared mem_system
    output logic [15:0] m_addr,
    output logic [15:0] m_data_in,
    output logic        m_rd,
    output logic        m_wr,
    input  logic [15:0] m_data_out,
    input  logic        m_done,
    input  logic        m_stall,
    input  logic        m_cache_hit,
    input  logic        m_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    // Per-port result registers returned to the requester.
    typedef struct packed {
        logic        done;
        logic        err;
        logic        hit;
        logic [15:0] data;
    } rsp_t;

    // Counter value seen in the last BUSY cycle before the abort.
    localparam logic [7:0] LAST_BUSY_CNT = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q,      state_d;
    port_t       grant_q,      grant_d;
    port_t       last_grant_q, last_grant_d;
    logic [7:0]  cnt_q,        cnt_d;
    logic [15:0] addr_q,       addr_d;
    logic [15:0] wdata_q,      wdata_d;
    logic        rd_q,         rd_d;
    logic        wr_q,         wr_d;
    rsp_t        i_rsp_q,      i_rsp_d;
    rsp_t        d_rsp_q,      d_rsp_d;

    logic        i_req;
    logic        d_req;
    port_t       winner;
    logic        win_rd;
    logic        win_wr;
    logic [15:0] win_addr;
    logic [15:0] win_data;

    // Completion event produced by the FSM and routed to one port.
    logic        fin_valid;
    port_t       fin_port;
    logic        fin_err;
    logic        fin_hit;
    logic        fin_capture;

    // m_stall is informational only; sequencing relies on m_done alone.
    logic        unused_m_stall;
    assign unused_m_stall = m_stall;

    assign i_req = i_rd | i_wr;
    assign d_req = d_rd | d_wr;

    // Arbitration: a lone requester wins, a tie goes to the port not served last.
    always_comb begin
        winner = PORT_I;
        if (i_req && d_req) begin
            winner = (last_grant_q == PORT_I) ? PORT_D : PORT_I;
        end else if (d_req) begin
            winner = PORT_D;
        end
    end

    assign win_rd   = (winner == PORT_D) ? d_rd      : i_rd;
    assign win_wr   = (winner == PORT_D) ? d_wr      : i_wr;
    assign win_addr = (winner == PORT_D) ? d_addr    : i_addr;
    assign win_data = (winner == PORT_D) ? d_data_in : i_data_in;

    // Next-state logic: grant and latch in IDLE, wait for Done or timeout in BUSY.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // through this block leaves a value unassigned and infers a latch.
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        fin_valid    = 1'b0;
        fin_port     = grant_q;
        fin_err      = 1'b0;
        fin_hit      = 1'b0;
        fin_capture  = 1'b0;

        unique case (state_q)
            IDLE: begin
                rd_d = 1'b0;
                wr_d = 1'b0;
                if (i_req || d_req) begin
                    grant_d      = winner;
                    last_grant_d = winner;
                    cnt_d        = 8'd0;
                    addr_d       = win_addr;
                    wdata_d      = win_data;
                    if (win_rd && win_wr) begin
                        // Read and write together is rejected without touching memory.
                        state_d   = DRAIN;
                        fin_valid = 1'b1;
                        fin_port  = winner;
                        fin_err   = 1'b1;
                    end else begin
                        state_d = BUSY;
                        rd_d    = win_rd;
                        wr_d    = win_wr;
                    end
                end
            end

            BUSY: begin
                cnt_d = cnt_q + 8'd1;
                if (m_done) begin
                    state_d     = DRAIN;
                    rd_d        = 1'b0;
                    wr_d        = 1'b0;
                    fin_valid   = 1'b1;
                    fin_err     = m_err;
                    fin_hit     = m_cache_hit;
                    fin_capture = 1'b1;
                end else if (cnt_q == LAST_BUSY_CNT) begin
                    // Abort: report an error but keep the previous read data.
                    state_d   = DRAIN;
                    rd_d      = 1'b0;
                    wr_d      = 1'b0;
                    fin_valid = 1'b1;
                    fin_err   = 1'b1;
                end
            end

            DRAIN: begin
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                state_d = IDLE;
            end

            default: begin
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Response routing: done/err are single-cycle, hit/data hold until the next completion.
    always_comb begin
        i_rsp_d      = i_rsp_q;
        d_rsp_d      = d_rsp_q;
        i_rsp_d.done = 1'b0;
        i_rsp_d.err  = 1'b0;
        d_rsp_d.done = 1'b0;
        d_rsp_d.err  = 1'b0;
        if (fin_valid) begin
            if (fin_port == PORT_D) begin
                d_rsp_d.done = 1'b1;
                d_rsp_d.err  = fin_err;
                d_rsp_d.hit  = fin_hit;
                if (fin_capture) begin
                    d_rsp_d.data = m_data_out;
                end
            end else begin
                i_rsp_d.done = 1'b1;
                i_rsp_d.err  = fin_err;
                i_rsp_d.hit  = fin_hit;
                if (fin_capture) begin
                    i_rsp_d.data = m_data_out;
                end
            end
        end
    end

    // State and datapath registers; reset drops any downstream access at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= PORT_I;
            last_grant_q <= PORT_D;
            cnt_q        <= 8'd0;
            addr_q       <= 16'd0;
            wdata_q      <= 16'd0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            i_rsp_q      <= '0;
            d_rsp_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register update from the
            // same pre-edge values, independent of statement order.
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            i_rsp_q      <= i_rsp_d;
            d_rsp_q      <= d_rsp_d;
        end
    end

    assign m_addr      = addr_q;
    assign m_data_in   = wdata_q;
    assign m_rd        = rd_q;
    assign m_wr        = wr_q;

    assign i_done      = i_rsp_q.done;
    assign i_err       = i_rsp_q.err;
    assign i_cache_hit = i_rsp_q.hit;
    assign i_data_out  = i_rsp_q.data;

    assign d_done      = d_rsp_q.done;
    assign d_err       = d_rsp_q.err;
    assign d_cache_hit = d_rsp_q.hit;
    assign d_data_out  = d_rsp_q.data;

    // A port stalls whenever it is requesting and is not being completed.
    assign i_stall = i_req & ~i_rsp_q.done;
    assign d_stall = d_req & ~d_rsp_q.done;

endmodule
